// File: rtl/vdp_host_port.sv
// vdp_host_port: CPU-facing write port for the VDP name RAM.
// The host programs a 12-bit auto-incrementing pointer, then writes 16-bit
// {tile_name, tile_attributes} words. The words are queued in a small show-ahead
// FIFO and drained one per cycle whenever the nameram arbiter is ready.
module vdp_host_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        dot_clk,
  input  logic        reset_n,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [11:0] nameram_write_addr,
  output logic [15:0] nameram_write_data,
  output logic        nameram_write_en,
  input  logic        nameram_write_ready
);

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA_LO = 2'd2;
  localparam logic [1:0] REG_DATA_HI = 2'd3;

  localparam logic [3:0] LEVEL_FULL = 4'(FIFO_DEPTH);

  // Host-visible registers
  logic [11:0] ptr_reg;
  logic        incr_row_reg;
  logic [7:0]  data_lo_reg;
  logic        overflow_reg;
  logic [7:0]  rdata_reg;

  // FIFO bookkeeping; each entry is {addr[11:0], name[7:0], attr[7:0]}
  logic [27:0]        fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] head_reg;
  logic [FIFO_AW-1:0] tail_reg;
  logic [3:0]         level_reg;
  logic [3:0]         level_next;

  logic        wr_access;
  logic        rd_access;
  logic        push_req;
  logic        push_ok;
  logic        push_reject;
  logic        pop;
  logic        full;
  logic        empty;
  logic [11:0] ptr_step;
  logic [11:0] ptr_inc;
  logic [7:0]  status;
  logic [7:0]  rdata_next;
  logic [27:0] head_entry;

  // Access decode, FIFO flags and pointer arithmetic
  always_comb begin
    wr_access   = cpu_cs & cpu_we;
    rd_access   = cpu_cs & ~cpu_we;
    full        = (level_reg == LEVEL_FULL);
    empty       = (level_reg == 4'd0);
    push_req    = wr_access & (cpu_addr == REG_DATA_HI);
    // Acceptance looks only at the level at the start of the cycle, so a
    // concurrent pop never makes room for a push on a full FIFO.
    push_ok     = push_req & ~full;
    push_reject = push_req & full;
    pop         = ~empty & nameram_write_ready;
    ptr_step    = incr_row_reg ? 12'd64 : 12'd1;
    ptr_inc     = ptr_reg + ptr_step;
    status      = {overflow_reg, full, empty, 1'b0, level_reg};
  end

  // Next FIFO level from the push/pop combination
  always_comb begin
    level_next = level_reg;
    case ({push_ok, pop})
      2'b10:   level_next = level_reg + 4'd1;
      2'b01:   level_next = level_reg - 4'd1;
      default: level_next = level_reg;
    endcase
  end

  // Read data multiplexer for the register map
  always_comb begin
    rdata_next = rdata_reg;
    if (rd_access) begin
      case (cpu_addr)
        REG_ADDR_LO: rdata_next = ptr_reg[7:0];
        REG_ADDR_HI: rdata_next = {incr_row_reg, 3'b000, ptr_reg[11:8]};
        REG_DATA_LO: rdata_next = data_lo_reg;
        default:     rdata_next = status;
      endcase
    end
  end

  // Pointer, staging byte, sticky overflow and registered read data
  always_ff @(posedge dot_clk) begin
    if (!reset_n) begin
      ptr_reg      <= '0;
      incr_row_reg <= 1'b0;
      data_lo_reg  <= '0;
      overflow_reg <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      rdata_reg <= rdata_next;
      if (wr_access) begin
        case (cpu_addr)
          REG_ADDR_LO: ptr_reg[7:0] <= cpu_wdata;
          REG_ADDR_HI: begin
            ptr_reg[11:8] <= cpu_wdata[3:0];
            incr_row_reg  <= cpu_wdata[7];
          end
          REG_DATA_LO: data_lo_reg <= cpu_wdata;
          default: begin
            if (push_ok) ptr_reg <= ptr_inc;
          end
        endcase
      end
      // A rejected push wins over the clear-on-read of STATUS.
      if (push_reject) begin
        overflow_reg <= 1'b1;
      end else if (rd_access && cpu_addr == REG_DATA_HI) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // FIFO head/tail indices and level; reset discards any queued words
  always_ff @(posedge dot_clk) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
      if (push_ok) tail_reg <= tail_reg + 1'b1;
      if (pop)     head_reg <= head_reg + 1'b1;
    end
  end

  // FIFO storage: one register per entry, loaded when the tail points at it
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge dot_clk) begin
        if (push_ok && tail_reg == FIFO_AW'(gi)) begin
          fifo_mem[gi] <= {ptr_reg, cpu_wdata, data_lo_reg};
        end
      end
    end
  endgenerate

  // Show-ahead head; outputs are forced to zero while nothing is queued
  always_comb begin
    head_entry         = fifo_mem[head_reg];
    nameram_write_en   = ~empty;
    nameram_write_addr = empty ? 12'd0 : head_entry[27:16];
    nameram_write_data = empty ? 16'd0 : head_entry[15:0];
  end

  assign cpu_rdata = rdata_reg;

endmodule
